// File: rtl/nios0_debug_pkg.sv
// Shared constants and types for the debug-slave command engine.
// IR codes name the four command classes decoded on the OCI side.
package nios0_debug_pkg;

  localparam int DEF_DATA_W     = 38;
  localparam int DEF_IR_W       = 2;
  localparam int DEF_ACTION_BIT = 34;

  localparam logic [DEF_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DEF_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEF_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [DEF_IR_W-1:0]   ir;
    logic [DEF_DATA_W-1:0] jdo;
  } dbg_cmd_t;

endpackage

// File: rtl/nios0_debug_sync_edge.sv
// Synchronizes an asynchronous level, suppresses edges until armed after reset,
// and emits a registered one-cycle pulse on each synchronized rising edge.
module nios0_debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_pulse
);

  localparam int ARM_CNT = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_CNT + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [ARM_W-1:0]       r_arm_cnt;
  logic                   r_pulse;
  logic                   w_level;
  logic                   w_armed;

  assign w_level = r_sync[SYNC_STAGES-1];
  assign w_armed = (r_arm_cnt == ARM_W'(ARM_CNT));
  assign o_pulse = r_pulse;

  // r_prev keeps tracking during arming, so a level already high when the
  // gate opens never looks like a rising edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync    <= '0;
      r_prev    <= 1'b0;
      r_arm_cnt <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev  <= w_level;
      r_pulse <= w_armed && w_level && !r_prev;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

endmodule

// File: rtl/nios0_debug_slave_cmd_engine.sv
// System-clock half of the debug slave: captures {ir, sr} on virtual-JTAG
// update strobes and queues them as a valid/ready command stream.
module nios0_debug_slave_cmd_engine
  import nios0_debug_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IR_W        = DEF_IR_W,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACTION_BIT  = DEF_ACTION_BIT,
  parameter int NUM_IR      = 2 ** IR_W,
  parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [DATA_W-1:0] cmd_jdo,
  output logic [NUM_IR-1:0] cmd_action,
  output logic [NUM_IR-1:0] cmd_no_action,
  output logic              uir_pulse,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = IR_W + DATA_W;

  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [IR_W-1:0]    r_ir_latch;
  logic               r_overflow;

  logic               w_uir_pulse;
  logic               w_udr_pulse;
  logic [IR_W-1:0]    w_push_ir;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_head;

  nios0_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (vs_uir),
    .o_pulse (w_uir_pulse)
  );

  nios0_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (vs_udr),
    .o_pulse (w_udr_pulse)
  );

  // Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready;
  // cmd_ready is ignored while cmd_valid is low, and the head holds until taken.
  assign w_push_ir = w_uir_pulse ? ir_in : r_ir_latch;
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = (r_count != '0) && cmd_ready;
  assign w_push    = w_udr_pulse && (!w_full || w_pop);
  assign w_drop    = w_udr_pulse && !w_push;
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ir_latch <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_uir_pulse) r_ir_latch <= ir_in;
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_push_ir, sr};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (overflow_clr)  r_overflow <= 1'b0;
      else if (w_drop)   r_overflow <= 1'b1;
    end
  end

  assign cmd_valid  = (r_count != '0);
  assign cmd_ir     = w_head[ENTRY_W-1:DATA_W];
  assign cmd_jdo    = w_head[DATA_W-1:0];
  assign uir_pulse  = w_uir_pulse;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

  always_comb begin
    cmd_action    = '0;
    cmd_no_action = '0;
    for (int i = 0; i < NUM_IR; i++) begin
      cmd_action[i]    = cmd_valid && (cmd_ir == IR_W'(i)) &&  cmd_jdo[ACTION_BIT];
      cmd_no_action[i] = cmd_valid && (cmd_ir == IR_W'(i)) && !cmd_jdo[ACTION_BIT];
    end
  end

endmodule

// File: tb/tb_nios0_debug_slave_cmd_engine.sv
// Scenario bench for the debug-slave command engine with a queue-based model
// of the command FIFO, the IR latch and the sticky overflow flag.
module tb_nios0_debug_slave_cmd_engine;

  localparam int DW = 38;
  localparam int IW = 2;
  localparam int AB = 34;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset_n;
  logic          vs_uir;
  logic          vs_udr;
  logic [IW-1:0] ir_in;
  logic [DW-1:0] sr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_ir;
  logic [DW-1:0] cmd_jdo;
  logic [3:0]    cmd_action;
  logic [3:0]    cmd_no_action;
  logic          uir_pulse;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic          overflow_clr;

  logic [IW+DW-1:0] exp_q[$];
  logic [IW-1:0]    model_ir;
  logic             model_ovf;
  int               n_checks;
  int               n_errors;

  nios0_debug_slave_cmd_engine dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .vs_uir        (vs_uir),
    .vs_udr        (vs_udr),
    .ir_in         (ir_in),
    .sr            (sr),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_ir        (cmd_ir),
    .cmd_jdo       (cmd_jdo),
    .cmd_action    (cmd_action),
    .cmd_no_action (cmd_no_action),
    .uir_pulse     (uir_pulse),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_sr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // drivers: each operation runs to completion and updates the model
  task automatic do_push(input logic upd_ir, input logic [IW-1:0] ir, input logic [DW-1:0] data);
    vs_uir = upd_ir;
    vs_udr = 1'b1;
    ir_in  = ir;
    sr     = data;
    if (upd_ir) model_ir = ir;
    if (exp_q.size() < DEPTH) exp_q.push_back({model_ir, data});
    else model_ovf = 1'b1;
    step(4);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic do_pop();
    cmd_ready = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    step(1);
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vs_udr  = 1'b1;
    step(3);
    n_checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || uir_pulse !== 1'b0 ||
        cmd_action !== 4'd0 || cmd_no_action !== 4'd0 || cmd_ir !== 2'd0 || cmd_jdo !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b count=%0d ovf=%b uirp=%b act=%b noact=%b ir=%0d jdo=%h expected all zero",
               cmd_valid, fifo_count, overflow, uir_pulse, cmd_action, cmd_no_action, cmd_ir, cmd_jdo);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_checks++;
      if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
        n_errors++;
        $display("FAIL arm_no_push cyc%0d: valid=%b count=%0d expected 0/0", i, cmd_valid, fifo_count);
      end
    end
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic test_single();
    vs_uir = 1'b1;
    ir_in  = 2'd2;
    model_ir = 2'd2;
    step(2);
    n_checks++;
    if (uir_pulse !== 1'b0) begin n_errors++; $display("FAIL uir_pulse_early: got %b expected 0", uir_pulse); end
    step(1);
    n_checks++;
    if (uir_pulse !== 1'b1) begin n_errors++; $display("FAIL uir_pulse: got %b expected 1", uir_pulse); end
    step(1);
    n_checks++;
    if (uir_pulse !== 1'b0) begin n_errors++; $display("FAIL uir_pulse_width: got %b expected 0", uir_pulse); end
    vs_uir = 1'b0;
    step(3);
    sr     = 38'h4_0000_1234;
    vs_udr = 1'b1;
    ir_in  = 2'd1;
    exp_q.push_back({model_ir, sr});
    step(3);
    n_checks++;
    if (cmd_valid !== 1'b0) begin n_errors++; $display("FAIL latency_early: valid=%b expected 0", cmd_valid); end
    step(1);
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_ir !== 2'd2 || cmd_jdo !== 38'h4_0000_1234 ||
        cmd_action !== 4'b0100 || cmd_no_action !== 4'b0000 || fifo_count !== 3'd1) begin
      n_errors++;
      $display("FAIL single_cmd: valid=%b ir=%0d jdo=%h act=%b noact=%b count=%0d expected 1/2/4000001234/0100/0000/1",
               cmd_valid, cmd_ir, cmd_jdo, cmd_action, cmd_no_action, fifo_count);
    end
    vs_udr = 1'b0;
    step(4);
    do_pop();
    n_checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_errors++;
      $display("FAIL single_pop: valid=%b count=%0d expected 0/0", cmd_valid, fifo_count);
    end
  endtask

  task automatic test_overflow();
    logic [IW+DW-1:0] e;
    for (int i = 0; i < 5; i++) do_push(1'b0, IW'($urandom_range(0, 3)), rand_sr());
    n_checks++;
    if (fifo_count !== 3'd4 || overflow !== model_ovf || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_fill: count=%0d ovf=%b expected 4/1", fifo_count, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q[0];
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_ir !== e[IW+DW-1:DW] || cmd_jdo !== e[DW-1:0]) begin
        n_errors++;
        $display("FAIL ovf_order%0d: valid=%b ir=%0d jdo=%h expected 1/%0d/%h",
                 i, cmd_valid, cmd_ir, cmd_jdo, e[IW+DW-1:DW], e[DW-1:0]);
      end
      do_pop();
    end
    n_checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_drained: valid=%b count=%0d ovf=%b expected 0/0/1", cmd_valid, fifo_count, overflow);
    end
    overflow_clr = 1'b1;
    model_ovf = 1'b0;
    step(1);
    overflow_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [IW+DW-1:0] e;
    for (int i = 0; i < 4; i++) do_push(1'b0, 2'd0, rand_sr());
    sr     = rand_sr();
    vs_udr = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back({model_ir, sr});
    step(3);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    e = exp_q[0];
    n_checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || cmd_jdo !== e[DW-1:0]) begin
      n_errors++;
      $display("FAIL full_push_pop: count=%0d ovf=%b jdo=%h expected 4/0/%h", fifo_count, overflow, cmd_jdo, e[DW-1:0]);
    end
    vs_udr = 1'b0;
    step(4);
    for (int i = 0; i < 4; i++) begin
      e = exp_q[0];
      n_checks++;
      if (cmd_jdo !== e[DW-1:0] || cmd_ir !== e[IW+DW-1:DW]) begin
        n_errors++;
        $display("FAIL full_drain%0d: ir=%0d jdo=%h expected %0d/%h", i, cmd_ir, cmd_jdo, e[IW+DW-1:DW], e[DW-1:0]);
      end
      do_pop();
    end
  endtask

  task automatic test_coincident();
    logic [DW-1:0] d;
    d = rand_sr();
    d[AB] = 1'b0;
    do_push(1'b1, 2'd3, d);
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_ir !== 2'd3 || cmd_no_action !== 4'b1000 || cmd_action !== 4'b0000 ||
        cmd_jdo !== d) begin
      n_errors++;
      $display("FAIL coincident: valid=%b ir=%0d act=%b noact=%b jdo=%h expected 1/3/0000/1000/%h",
               cmd_valid, cmd_ir, cmd_action, cmd_no_action, cmd_jdo, d);
    end
    do_pop();
  endtask

  task automatic test_reset_flush();
    logic [DW-1:0] d;
    for (int i = 0; i < 3; i++) do_push(1'b0, 2'd0, rand_sr());
    n_checks++;
    if (fifo_count !== 3'd3) begin n_errors++; $display("FAIL flush_fill: count=%0d expected 3", fifo_count); end
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    exp_q.delete();
    model_ir  = '0;
    model_ovf = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd0 || cmd_valid !== 1'b0 || cmd_jdo !== '0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL flush: count=%0d valid=%b jdo=%h ovf=%b expected 0/0/0/0", fifo_count, cmd_valid, cmd_jdo, overflow);
    end
    step(5);
    d = rand_sr();
    do_push(1'b0, 2'd1, d);
    n_checks++;
    if (fifo_count !== 3'd1 || cmd_jdo !== d || cmd_ir !== 2'd0) begin
      n_errors++;
      $display("FAIL flush_fresh: count=%0d ir=%0d jdo=%h expected 1/0/%h", fifo_count, cmd_ir, cmd_jdo, d);
    end
    do_pop();
  endtask

  task automatic test_random();
    int               op;
    logic [IW+DW-1:0] e;
    logic [3:0]       exp_act;
    logic [3:0]       exp_nact;
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 6));
      if (op <= 2) do_push(1'b0, IW'($urandom_range(0, 3)), rand_sr());
      else if (op == 3) do_push(1'b1, IW'($urandom_range(0, 3)), rand_sr());
      else if (op == 4 || op == 5) do_pop();
      else begin
        overflow_clr = 1'b1;
        model_ovf = 1'b0;
        step(1);
        overflow_clr = 1'b0;
      end
      exp_act  = '0;
      exp_nact = '0;
      e = '0;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (e[AB]) exp_act[e[IW+DW-1:DW]] = 1'b1;
        else exp_nact[e[IW+DW-1:DW]] = 1'b1;
      end
      n_checks++;
      if (cmd_valid !== (exp_q.size() > 0) || fifo_count !== 3'(exp_q.size()) || overflow !== model_ovf ||
          cmd_action !== exp_act || cmd_no_action !== exp_nact ||
          (exp_q.size() > 0 && (cmd_ir !== e[IW+DW-1:DW] || cmd_jdo !== e[DW-1:0]))) begin
        n_errors++;
        $display("FAIL random it%0d op%0d: valid=%b count=%0d ovf=%b act=%b noact=%b ir=%0d jdo=%h expected count=%0d ovf=%b act=%b noact=%b ir=%0d jdo=%h",
                 it, op, cmd_valid, fifo_count, overflow, cmd_action, cmd_no_action, cmd_ir, cmd_jdo,
                 exp_q.size(), model_ovf, exp_act, exp_nact, e[IW+DW-1:DW], e[DW-1:0]);
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    model_ir     = '0;
    model_ovf    = 1'b0;
    reset_n      = 1'b0;
    vs_uir       = 1'b0;
    vs_udr       = 1'b0;
    ir_in        = '0;
    sr           = '0;
    cmd_ready    = 1'b0;
    overflow_clr = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_coincident();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
